// File: rtl/systolic_operand_packer.sv
// Packs IN_WIDTH DMA words little-endian into OUT_WIDTH operand vectors, zero-padding on EOP.
// One-cycle push-to-valid latency; input stalls only when the vector FIFO is full.
module operand_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module systolic_operand_packer #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock_sink,
  input  logic                          reset_sink_reset,
  input  logic [IN_WIDTH-1:0]           st_in_data,
  input  logic                          st_in_valid,
  output logic                          st_in_ready,
  input  logic                          st_in_endofpacket,
  output logic [OUT_WIDTH-1:0]          st_out_data,
  output logic                          st_out_valid,
  input  logic                          st_out_ready,
  output logic                          st_out_endofpacket,
  output logic [15:0]                   vec_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int WPV = OUT_WIDTH / IN_WIDTH;
  localparam int BW  = (WPV > 1) ? $clog2(WPV) : 1;
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;

  logic [BW-1:0]        beat_cnt;
  logic [OUT_WIDTH-1:0] asm_q;
  logic [OUT_WIDTH-1:0] merged;
  logic                 accept;
  logic                 complete;
  logic                 pop;
  logic [OUT_WIDTH:0]   head;

  assign st_in_ready = !reset_sink_reset && (fifo_level < LW'(FIFO_DEPTH));
  assign accept      = st_in_valid && st_in_ready;
  assign complete    = accept && ((beat_cnt == BW'(WPV - 1)) || st_in_endofpacket);
  assign pop         = st_out_valid && st_out_ready;

  // Lanes above the current beat are already zero, so the merge doubles as the pad.
  always_comb begin
    merged = asm_q;
    merged[beat_cnt * IN_WIDTH +: IN_WIDTH] = st_in_data;
  end

  always_ff @(posedge clock_sink) begin
    if (reset_sink_reset) begin
      beat_cnt  <= '0;
      asm_q     <= '0;
      vec_count <= '0;
    end else begin
      if (complete) begin
        beat_cnt <= '0;
        asm_q    <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
        asm_q    <= merged;
      end
      if (pop) vec_count <= vec_count + 16'd1;
    end
  end

  operand_fifo #(
    .WIDTH (OUT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clock_sink),
    .rst      (reset_sink_reset),
    .push     (complete),
    .push_dat ({st_in_endofpacket, merged}),
    .pop      (pop),
    .head_dat (head),
    .level    (fifo_level)
  );

  assign st_out_valid       = (fifo_level != '0);
  assign st_out_data        = head[OUT_WIDTH-1:0];
  assign st_out_endofpacket = st_out_valid && head[OUT_WIDTH];
endmodule

// File: tb/tb_systolic_operand_packer.sv
// Scoreboard bench for systolic_operand_packer: a word-level model queues expected vectors.
module tb_systolic_operand_packer;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  st_in_data;
  logic         st_in_valid;
  logic         st_in_ready;
  logic         st_in_endofpacket;
  logic [255:0] st_out_data;
  logic         st_out_valid;
  logic         st_out_ready;
  logic         st_out_endofpacket;
  logic [15:0]  vec_count;
  logic [2:0]   fifo_level;

  int n_checks = 0;
  int n_fails  = 0;
  int mdl_pops = 0;
  int mdl_beat = 0;
  logic [255:0] mdl_asm = '0;
  logic [256:0] sb [$];

  always #5 clk = ~clk;

  systolic_operand_packer dut (
    .clock_sink         (clk),
    .reset_sink_reset   (rst),
    .st_in_data         (st_in_data),
    .st_in_valid        (st_in_valid),
    .st_in_ready        (st_in_ready),
    .st_in_endofpacket  (st_in_endofpacket),
    .st_out_data        (st_out_data),
    .st_out_valid       (st_out_valid),
    .st_out_ready       (st_out_ready),
    .st_out_endofpacket (st_out_endofpacket),
    .vec_count          (vec_count),
    .fifo_level         (fifo_level)
  );

  task automatic check(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output side: a pop happens at the next rising edge whenever valid && ready here.
  always @(negedge clk) begin
    if (!rst && st_out_valid && st_out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 257'd1, 257'd0);
      end else begin
        logic [256:0] e;
        e = sb.pop_front();
        check("vec_data", {1'b0, st_out_data}, {1'b0, e[255:0]});
        check("vec_eop", {256'd0, st_out_endofpacket}, {256'd0, e[256]});
      end
      mdl_pops++;
    end
  end

  task automatic send_word(input logic [31:0] d, input logic e);
    int n = 0;
    st_in_data = d;
    st_in_endofpacket = e;
    st_in_valid = 1'b1;
    @(negedge clk);
    while (!st_in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!st_in_ready) begin
      check("in_timeout", 257'd0, 257'd1);
      st_in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    st_in_valid = 1'b0;
    st_in_endofpacket = 1'b0;
    mdl_asm[mdl_beat*32 +: 32] = d;
    if (mdl_beat == 7 || e) begin
      sb.push_back({e, mdl_asm});
      mdl_asm = '0;
      mdl_beat = 0;
    end else begin
      mdl_beat++;
    end
  endtask

  task automatic drain();
    int n = 0;
    st_out_ready = 1'b1;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 257'(sb.size()), 257'd0);
    check("vec_count", {241'd0, vec_count}, 257'(mdl_pops[15:0]));
  endtask

  initial begin
    rst = 1'b1;
    st_in_data = '0;
    st_in_valid = 1'b0;
    st_in_endofpacket = 1'b0;
    st_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {256'd0, st_in_ready}, 257'd0);
    check("rst_out_valid", {256'd0, st_out_valid}, 257'd0);
    check("rst_out_eop", {256'd0, st_out_endofpacket}, 257'd0);
    check("rst_level", 257'(fifo_level), 257'd0);
    check("rst_vec_count", 257'(vec_count), 257'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full 8-beat vector with byte lane i == i; valid must rise one cycle after the last accept.
    st_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      send_word(w, 1'b0);
    end
    check("t1_latency_valid", {256'd0, st_out_valid}, 257'd1);
    check("t1_head_lanes", {1'b0, st_out_data},
          {1'b0, 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100});
    drain();

    // Short EOP vector, then a new vector that must restart at lane 0.
    send_word(32'haaaa0001, 1'b0);
    send_word(32'hbbbb0002, 1'b0);
    send_word(32'hcccc0003, 1'b1);
    check("t2_eop_flag", {256'd0, st_out_endofpacket}, 257'd1);
    send_word(32'hdddd0004, 1'b1);
    drain();

    // Fill the FIFO with the consumer stalled; the 33rd word must be held.
    st_out_ready = 1'b0;
    for (int i = 0; i < 32; i++) send_word(32'h3300_0000 + 32'(i), 1'b0);
    check("t3_level_full", 257'(fifo_level), 257'd4);
    check("t3_in_ready_low", {256'd0, st_in_ready}, 257'd0);
    fork
      send_word(32'h3300_0020, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("t3_held_level", 257'(fifo_level), 257'd4);
        check("t3_held_ready", {256'd0, st_in_ready}, 257'd0);
        st_out_ready = 1'b1;
      end
    join
    for (int i = 33; i < 40; i++) send_word(32'h3300_0000 + 32'(i), 1'b0);
    drain();

    // Level 2, then a completing push coinciding with a pop.
    st_out_ready = 1'b0;
    for (int i = 0; i < 23; i++) send_word($urandom, 1'b0);
    check("t4_level_pre", 257'(fifo_level), 257'd2);
    st_out_ready = 1'b1;
    send_word($urandom, 1'b0);
    st_out_ready = 1'b0;
    check("t4_level_same", 257'(fifo_level), 257'd2);
    drain();

    // Reset mid-vector with two vectors buffered.
    st_out_ready = 1'b0;
    for (int i = 0; i < 21; i++) send_word($urandom, 1'b0);
    rst = 1'b1;
    #1;
    check("t5_in_ready_rst", {256'd0, st_in_ready}, 257'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    mdl_asm = '0;
    mdl_beat = 0;
    mdl_pops = 0;
    check("t5_valid", {256'd0, st_out_valid}, 257'd0);
    check("t5_level", 257'(fifo_level), 257'd0);
    check("t5_vec_count", 257'(vec_count), 257'd0);
    st_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_word(32'h5500_0000 + 32'(i), 1'b0);
    drain();

    // 65536 single-word EOP vectors: vec_count wraps back to the same value.
    st_out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) send_word($urandom, 1'b1);
    drain();
    check("t6_wrap", 257'(vec_count), 257'd1);
    check("t6_pop_total", 257'(mdl_pops), 257'd65537);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
